// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    localparam int FRAME_WIDTH = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    // Value the parity bit must carry for the given data and parity type.
    function automatic logic expectedParity(input logic [FRAME_WIDTH-1:0] data,
                                            input logic                   ptype);
        return (ptype == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Edge/bit counters and mid-bit sampling for the UART receiver.
// Define UART_RX_MAJORITY_SAMPLE_EN for 2-of-3 majority sampling (one cycle later).
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       enable_i,
    output logic       bit_o,
    output logic       bit_valid_o,
    output logic       bit_end_o,
    output logic [3:0] bit_cnt_o
);

    localparam int            CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_SAMPLE_EN
    localparam logic [CW-1:0] EARLY = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LATE  = CW'(OVERSAMPLE / 2 + 1);

    logic early_q;
    logic mid_q;
`endif

    logic [CW-1:0] edgeCnt_q;
    logic [3:0]    bitCnt_q;
    logic          bit_q;
    logic          bitValid_q;
    logic          bitEnd_q;

    // Counters idle at zero while disabled, so the first enabled cycle is edge 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edgeCnt_q  <= '0;
            bitCnt_q   <= '0;
            bit_q      <= 1'b1;
            bitValid_q <= 1'b0;
            bitEnd_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
            early_q    <= 1'b1;
            mid_q      <= 1'b1;
`endif
        end else begin
            bitValid_q <= 1'b0;
            bitEnd_q   <= 1'b0;
            if (!enable_i) begin
                edgeCnt_q <= '0;
                bitCnt_q  <= '0;
            end else begin
                if (edgeCnt_q == LAST) begin
                    edgeCnt_q <= '0;
                    bitCnt_q  <= bitCnt_q + 4'd1;
                    bitEnd_q  <= 1'b1;
                end else begin
                    edgeCnt_q <= edgeCnt_q + CW'(1);
                end
`ifdef UART_RX_MAJORITY_SAMPLE_EN
                if (edgeCnt_q == EARLY) early_q <= rx_i;
                if (edgeCnt_q == MID)   mid_q   <= rx_i;
                if (edgeCnt_q == LATE) begin
                    bit_q      <= (early_q & mid_q) | (early_q & rx_i) | (mid_q & rx_i);
                    bitValid_q <= 1'b1;
                end
`else
                if (edgeCnt_q == MID) begin
                    bit_q      <= rx_i;
                    bitValid_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign bit_o       = bit_q;
    assign bit_valid_o = bitValid_q;
    assign bit_end_o   = bitEnd_q;
    assign bit_cnt_o   = bitCnt_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, shift register, parity/stop checks, output registers.
// Sampling mode is selected by UART_RX_MAJORITY_SAMPLE_EN (see uart_rx_sampler).
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   parity_enable,
    input  logic                   parity_type,
    output logic [FRAME_WIDTH-1:0] P_DATA,
    output logic                   Data_Valid,
    output logic                   parity_error,
    output logic                   stop_error
);

    rx_state_t              state_q;
    logic [FRAME_WIDTH-1:0] shift_q;
    logic [FRAME_WIDTH-1:0] pData_q;
    logic                   dataValid_q;
    logic                   parityError_q;
    logic                   stopError_q;
    logic                   parErr_q;
    logic                   stopErr_q;
    logic                   parEn_q;
    logic                   parType_q;
    logic                   armed_q;

    logic       sampBit;
    logic       sampValid;
    logic       sampEnd;
    logic [3:0] sampCnt;
    logic       startDet;
    logic       sampEnable;

    // A start is only accepted after the line has been seen high, so a break re-arms cleanly.
    assign startDet   = (state_q == IDLE) && armed_q && !RX_IN;
    assign sampEnable = (state_q != IDLE) || startDet;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .rx_i        (RX_IN),
        .enable_i    (sampEnable),
        .bit_o       (sampBit),
        .bit_valid_o (sampValid),
        .bit_end_o   (sampEnd),
        .bit_cnt_o   (sampCnt)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            pData_q       <= '0;
            dataValid_q   <= 1'b0;
            parityError_q <= 1'b0;
            stopError_q   <= 1'b0;
            parErr_q      <= 1'b0;
            stopErr_q     <= 1'b0;
            parEn_q       <= 1'b0;
            parType_q     <= PARITY_EVEN;
            armed_q       <= 1'b0;
        end else begin
            dataValid_q   <= 1'b0;
            parityError_q <= 1'b0;
            stopError_q   <= 1'b0;
            if (RX_IN) armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (startDet) begin
                        state_q   <= START;
                        armed_q   <= 1'b0;
                        parEn_q   <= parity_enable;
                        parType_q <= parity_type;
                        parErr_q  <= 1'b0;
                        stopErr_q <= 1'b0;
                    end
                end
                START: begin
                    if (sampValid && sampBit) state_q <= IDLE;
                    else if (sampEnd)         state_q <= DATA;
                end
                DATA: begin
                    if (sampValid) shift_q <= {sampBit, shift_q[FRAME_WIDTH-1:1]};
                    if (sampEnd && sampCnt == 4'(FRAME_WIDTH + 1))
                        state_q <= parEn_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (sampValid) parErr_q <= (sampBit != expectedParity(shift_q, parType_q));
                    if (sampEnd)   state_q  <= STOP;
                end
                STOP: begin
                    // Leave as soon as the stop bit is decided so back-to-back starts are caught.
                    if (sampValid) begin
                        stopErr_q <= !sampBit;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (!parErr_q && !stopErr_q) begin
                        pData_q     <= shift_q;
                        dataValid_q <= 1'b1;
                    end else begin
                        parityError_q <= parErr_q;
                        stopError_q   <= stopErr_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign P_DATA       = pData_q;
    assign Data_Valid   = dataValid_q;
    assign parity_error = parityError_q;
    assign stop_error   = stopError_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected strobes, a negedge monitor pops and checks them.
module tb_uart_rx;

    localparam int OS = 8;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       parity_error;
    logic       stop_error;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
        int         cycle;
    } expEvent_t;

    expEvent_t  expQ[$];
    expEvent_t  monEv;
    int         checks = 0;
    int         errors = 0;
    int         edgeNum = 0;
    int         eventCnt = 0;
    int         baseCnt;
    logic [7:0] modelData = 8'h00;

    uart_rx #(
        .OVERSAMPLE (OS)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .P_DATA        (P_DATA),
        .Data_Valid    (Data_Valid),
        .parity_error  (parity_error),
        .stop_error    (stop_error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edgeNum <= edgeNum + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic driveBit(input logic v, input int n);
        @(negedge CLK);
        RX_IN = v;
        repeat (n - 1) @(negedge CLK);
    endtask

    // Sends one frame; the DUT sees the start bit on the posedge after the recorded negedge.
    task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parType,
                                 input logic parFlip, input logic stopVal);
        expEvent_t e;
        int        start;
        logic      pbit;
        pbit = (^data) ^ parType ^ parFlip;
        @(negedge CLK);
        parity_enable = parEn;
        parity_type   = parType;
        RX_IN         = 1'b0;
        start         = edgeNum;
        e.pe = parEn && parFlip;
        e.se = !stopVal;
        e.dv = !e.pe && !e.se;
        if (e.dv) modelData = data;
        e.data  = modelData;
        e.cycle = start + 1 + (parEn ? 10 : 9) * OS + OS / 2 + 2 + EXTRA;
        expQ.push_back(e);
        repeat (OS - 1) @(negedge CLK);
        for (int i = 0; i < 8; i++) driveBit(data[i], OS);
        if (parEn) driveBit(pbit, OS);
        driveBit(stopVal, OS);
        RX_IN = 1'b1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge CLK);
        checkOutput("drain", expQ.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (Data_Valid || parity_error || stop_error) begin
            eventCnt++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", {29'b0, Data_Valid, parity_error, stop_error}, 0);
            end else begin
                monEv = expQ.pop_front();
                checkOutput("data_valid", Data_Valid, monEv.dv);
                checkOutput("parity_error", parity_error, monEv.pe);
                checkOutput("stop_error", stop_error, monEv.se);
                checkOutput("p_data", P_DATA, monEv.data);
                checkOutput("strobe_cycle", edgeNum, monEv.cycle);
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        checkOutput("reset_p_data", P_DATA, 8'h00);
        checkOutput("reset_data_valid", Data_Valid, 0);
        checkOutput("reset_parity_error", parity_error, 0);
        checkOutput("reset_stop_error", stop_error, 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge CLK);
        applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);
        waitDrain();

        // Start glitch: two low cycles must not produce any frame.
        baseCnt = eventCnt;
        @(negedge CLK);
        parity_enable = 1'b0;
        RX_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (100) @(negedge CLK);
        checkOutput("glitch_quiet", eventCnt - baseCnt, 0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);

        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        waitDrain();

        // Break: one stop_error frame, then no re-arm until the line returns high.
        begin
            expEvent_t e;
            @(negedge CLK);
            parity_enable = 1'b0;
            RX_IN = 1'b0;
            e.dv    = 1'b0;
            e.pe    = 1'b0;
            e.se    = 1'b1;
            e.data  = modelData;
            e.cycle = edgeNum + 1 + 9 * OS + OS / 2 + 2 + EXTRA;
            expQ.push_back(e);
            repeat (9 * OS + 60) @(negedge CLK);
            RX_IN = 1'b1;
        end
        repeat (100) @(negedge CLK);
        waitDrain();

        // Reset in the middle of data bit 4.
        baseCnt = eventCnt;
        @(negedge CLK);
        RX_IN = 1'b0;
        repeat (OS - 1) @(negedge CLK);
        driveBit(1'b0, OS);
        driveBit(1'b1, OS);
        driveBit(1'b1, OS);
        driveBit(1'b0, OS);
        driveBit(1'b1, OS / 2);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("midreset_p_data", P_DATA, 8'h00);
        checkOutput("midreset_data_valid", Data_Valid, 0);
        checkOutput("midreset_parity_error", parity_error, 0);
        checkOutput("midreset_stop_error", stop_error, 0);
        modelData = 8'h00;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (100) @(negedge CLK);
        checkOutput("reset_quiet", eventCnt - baseCnt, 0);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        waitDrain();
        repeat (5) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
